// File: rtl/nerv_mem_arbiter.sv
// Shares one single-port synchronous memory between the nerv fetch and data ports.
// A data access steals one cycle from the fetch stream and stalls the core for it.
module nerv_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall_in,
    output logic                  stall,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    input  logic                  dmem_valid,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [3:0]            dmem_wstrb,
    input  logic [31:0]           dmem_wdata,
    output logic [31:0]           dmem_rdata,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic [CNT_WIDTH-1:0]  fetch_count,
    output logic [CNT_WIDTH-1:0]  data_count,
    output logic [CNT_WIDTH-1:0]  conflict_count
);

    typedef enum logic [0:0] {StFetch, StData} state_e;

    state_e               state_q, state_d;
    logic                 issue_fetch, issue_data;
    logic                 fetch_issued_q;  // mem_rdata currently carries fetch data
    logic                 load_pending_q;  // mem_rdata currently carries load data
    logic [31:0]          imem_hold_q;
    logic [31:0]          load_q;
    logic [CNT_WIDTH-1:0] fetch_cnt_q, data_cnt_q, conflict_cnt_q;

    always_comb begin
        state_d     = state_q;
        issue_fetch = 1'b0;
        issue_data  = 1'b0;
        stall       = 1'b0;
        mem_addr    = imem_addr;
        mem_wstrb   = 4'b0000;
        mem_wdata   = dmem_wdata;
        if (!reset) begin
            if (stall_in) begin
                stall = 1'b1;
            end else begin
                unique case (state_q)
                    StFetch: begin
                        if (dmem_valid) begin
                            issue_data = 1'b1;
                            stall      = 1'b1;
                            state_d    = StData;
                        end else begin
                            issue_fetch = 1'b1;
                        end
                    end
                    StData: begin
                        issue_fetch = 1'b1;
                        state_d     = StFetch;
                    end
                endcase
            end
        end
        mem_valid = issue_fetch | issue_data;
        if (issue_data) begin
            mem_addr  = dmem_addr;
            mem_wstrb = dmem_wstrb;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StFetch;
            fetch_issued_q <= 1'b0;
            load_pending_q <= 1'b0;
            imem_hold_q    <= 32'h0;
            load_q         <= 32'h0;
            fetch_cnt_q    <= '0;
            data_cnt_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            fetch_issued_q <= issue_fetch;
            load_pending_q <= issue_data && (dmem_wstrb == 4'b0000);
            if (fetch_issued_q) begin
                imem_hold_q <= mem_rdata;
            end
            // The capture runs even under stall_in: read data is only valid this one cycle.
            if (load_pending_q) begin
                load_q <= mem_rdata;
            end
            if (issue_fetch) begin
                fetch_cnt_q <= fetch_cnt_q + CNT_WIDTH'(1);
            end
            if (issue_data) begin
                data_cnt_q     <= data_cnt_q + CNT_WIDTH'(1);
                conflict_cnt_q <= conflict_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign imem_data      = fetch_issued_q ? mem_rdata : imem_hold_q;
    assign dmem_rdata     = load_q;
    assign fetch_count    = fetch_cnt_q;
    assign data_count     = data_cnt_q;
    assign conflict_count = conflict_cnt_q;

endmodule
